sdiv_seq: RTL and testbench
===========================

# sdiv_seq

Sequential signed integer divider, the inverse companion to the team's combinational 4-bit Baugh-Wooley multiplier.
- Takes two's-complement dividend and divisor of width N.
- Returns quotient and remainder with truncate-toward-zero semantics, so a·b products from the multiplier can be round-tripped in self-checks.
- Radix-2 non-restoring core: one quotient bit per clock, with a start/done handshake for use by the arithmetic test datapath.

## Interface
- N, default 4: operand width in bits; legal range 2 to 16.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- start  input  1  request pulse; sampled only when busy=0.
- a  input  N  signed dividend; captured on the accepting edge.
- b  input  N  signed divisor; captured on the accepting edge.
- q  output  N  signed quotient; held until the next accepted start.
- r  output  N  signed remainder; its sign equals the sign of a (or r=0).
- busy  output  1  high from the edge after acceptance until the edge that asserts done.
- done  output  1  one-cycle pulse; q, r and flags are valid in this cycle.
- dbz  output  1  divide-by-zero flag, valid with done.
- ovf  output  1  overflow flag (-2^(N-1) / -1), valid with done.

## Operation
- States:
  - IDLE: start accepted here → LOAD.
  - LOAD: form magnitudes and sign bits → CALC.
  - CALC: runs N cycles, counting down from N-1 to 0 → FIX.
  - FIX: final remainder restore and sign application → IDLE, with done=1 on the same edge.
- LOAD:
  - |a| and |b| are held as (N+1)-bit unsigned values, so |-2^(N-1)| is represented exactly.
  - sq = a[N-1]^b[N-1]; sr = a[N-1].
- CALC, per cycle:
  - Shift {P,A} left by one.
  - If P ≥ 0 then P = P - |b|, else P = P + |b|.
  - The new quotient LSB is ~P[sign].
  - P is an (N+2)-bit signed partial remainder.
- FIX:
  - If P < 0, add |b| back.
  - q = sq ? -A : A, truncated to N bits.
  - r = sr ? -P : P, truncated to N bits.
- Divide by zero (b = 0): detected in LOAD; CALC is still traversed so latency stays constant. Outputs are forced to q = all ones (-1), r = a, dbz = 1.
- Overflow (a = -2^(N-1), b = -1): q = -2^(N-1) (wrapped), r = 0, ovf = 1.
- dbz and ovf are never both set. Both clear on the next accepted start.
- start while busy=1 is ignored, with no queuing.
- start in the same cycle as done is also ignored, because busy is still 1 in that cycle.

## Timing
- Reset values: q = 0, r = 0, busy = 0, done = 0, dbz = 0, ovf = 0, state = IDLE, counter = 0.
- Start accepted at edge k (start=1, busy=0):
  - busy = 1 from cycle k+1.
  - done = 1 in cycle k+N+2 only.
  - busy falls at the edge ending cycle k+N+2, so the next start can be accepted at edge k+N+3.
  - Latency is N+2 cycles for every operand value, including dbz and ovf cases.
- Throughput: one division per N+3 cycles.
- rst asserted mid-operation: the operation is aborted and all outputs return to their reset values on that edge. done is never pulsed for an aborted operation.
- rst has priority over start on the same edge.

## Structure
- Shared package/include holds:
  - state encodings: IDLE=2'd0, LOAD=2'd1, CALC=2'd2, FIX=2'd3;
  - the sign-application negate helper;
  - the default N.
- One sub-module, addsub_nbit: (N+2)-bit ripple add/subtract (control bit sub) built from the team's existing full-adder cell. It is instantiated once in CALC and reused in FIX for the restore.
- Control FSM, counter and output registers live in sdiv_seq.

## Test plan
All scenarios run at N=4.
- 7 / 2 → q=3, r=1, dbz=0, ovf=0; done exactly 6 cycles after the accepting edge.
- -7 / 2 → q=-3 (4'b1101), r=-1 (4'b1111); 7 / -2 → q=-3, r=1; -7 / -2 → q=3, r=-1.
- -8 / -1 → q=-8 (4'b1000), r=0, ovf=1; -8 / 1 → q=-8, r=0, ovf=0.
- 5 / 0 → q=4'b1111, r=5, dbz=1, with latency still 6 cycles.
- Back-to-back requests:
  - start 3/3, then pulse start with 6/2 at cycle k+3 → the second request is ignored and the first gives q=1, r=0.
  - start 6/2 again at k+7 → q=3, r=0.
- Reset abort: rst high at cycle k+3 of a -7/3 operation → all outputs return to 0 next cycle and no done is seen.
- Exhaustive: all 256 (a, b) pairs are checked against a model of a/b and a%b, and q·b + r is cross-checked against the multiplier when b ≠ 0.

Source files
------------

// File: rtl/sdiv_seq_pkg.sv
// Shared definitions for the sequential signed divider: state encodings,
// the default operand width and the two's-complement sign-application helper.
package sdiv_seq_pkg;

  localparam int DefaultN = 4;

  // Widest vector the sign helper ever sees: (N+2) bits at the maximum N of 16.
  localparam int MaxW = 18;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CALC = 2'd2,
    FIX  = 2'd3
  } state_e;

  // Conditionally negate a value. Callers extend into MaxW bits and truncate
  // the result back to their own width. Negation is exact modulo 2^width.
  function automatic logic [MaxW-1:0] applySign(input logic neg, input logic [MaxW-1:0] v);
    return neg ? (~v + MaxW'(1)) : v;
  endfunction

endpackage

// File: rtl/sdiv_seq_addsub.sv
// Ripple-carry add/subtract built from single-bit full-adder cells.
// sub_i=1 computes x - y by inverting y and injecting a carry of one.

module FullAdder (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic sum_o,
  output logic cout_o
);

  // Single-bit sum and carry.
  always_comb begin
    sum_o  = a_i ^ b_i ^ cin_i;
    cout_o = (a_i & b_i) | (a_i & cin_i) | (b_i & cin_i);
  end

endmodule

module addsub_nbit #(
  parameter int W = 6
) (
  input  logic [W-1:0] x_i,
  input  logic [W-1:0] y_i,
  input  logic         sub_i,
  output logic [W-1:0] sum_o
);

  logic [W-1:0] yEff;
  logic [W-1:0] carry;

  // Invert the second operand and seed the carry chain for subtraction.
  always_comb begin
    yEff = y_i ^ {W{sub_i}};
  end

  assign carry[0] = sub_i;

  for (genvar i = 0; i < W; i++) begin : gBit
    if (i < W - 1) begin : gCell
      FullAdder uFa (
        .a_i   (x_i[i]),
        .b_i   (yEff[i]),
        .cin_i (carry[i]),
        .sum_o (sum_o[i]),
        .cout_o(carry[i+1])
      );
    end else begin : gTop
      // The carry out of the top bit would be discarded, so only its sum is formed.
      assign sum_o[i] = x_i[i] ^ yEff[i] ^ carry[i];
    end
  end

endmodule

// File: rtl/sdiv_seq.sv
// Sequential signed divider, radix-2 non-restoring, truncating toward zero.
// One quotient bit per clock; fixed latency of N+2 cycles from the accepting edge.
module sdiv_seq
  import sdiv_seq_pkg::*;
#(
  parameter int N = DefaultN
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic [N-1:0] q_o,
  output logic [N-1:0] r_o,
  output logic         busy_o,
  output logic         done_o,
  output logic         dbz_o,
  output logic         ovf_o
);

  localparam int W1 = N + 1;
  localparam int PW = N + 2;
  localparam int CW = $clog2(N);
  localparam logic [N-1:0] MinNeg = {1'b1, {(N-1){1'b0}}};

  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  aOp_q, aOp_d;
  logic [N-1:0]  bOp_q, bOp_d;
  logic [W1-1:0] magB_q, magB_d;
  logic [PW-1:0] p_q, p_d;
  logic [N-1:0]  quo_q, quo_d;
  logic          sq_q, sq_d;
  logic          sr_q, sr_d;
  logic          isDbz_q, isDbz_d;
  logic          isOvf_q, isOvf_d;
  logic [N-1:0]  q_q, q_d;
  logic [N-1:0]  r_q, r_d;
  logic          dbz_q, dbz_d;
  logic          ovf_q, ovf_d;

  logic [PW-1:0] addX;
  logic [PW-1:0] addY;
  logic          addSub;
  logic [PW-1:0] addSum;
  logic [PW-1:0] pFinal;
  logic [N-1:0]  qFix;
  logic [N-1:0]  rFix;

  // Shared adder: iteration step in CALC, remainder restore in FIX.
  always_comb begin
    addY = {1'b0, magB_q};
    if (state_q == FIX) begin
      addX   = p_q;
      addSub = 1'b0;
    end else begin
      addX   = {p_q[N:0], quo_q[N-1]};
      addSub = ~p_q[PW-1];
    end
  end

  addsub_nbit #(
    .W(PW)
  ) uAddSub (
    .x_i  (addX),
    .y_i  (addY),
    .sub_i(addSub),
    .sum_o(addSum)
  );

  // Final correction and sign application; divide-by-zero forces q=-1, r=a.
  always_comb begin
    pFinal = p_q[PW-1] ? addSum : p_q;
    if (isDbz_q) begin
      qFix = '1;
      rFix = aOp_q;
    end else begin
      qFix = N'(applySign(sq_q, MaxW'(quo_q)));
      rFix = N'(applySign(sr_q, MaxW'(pFinal)));
    end
  end

  // Next-state logic for the control FSM and the datapath registers.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    aOp_d   = aOp_q;
    bOp_d   = bOp_q;
    magB_d  = magB_q;
    p_d     = p_q;
    quo_d   = quo_q;
    sq_d    = sq_q;
    sr_d    = sr_q;
    isDbz_d = isDbz_q;
    isOvf_d = isOvf_q;
    q_d     = q_q;
    r_d     = r_q;
    dbz_d   = dbz_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          aOp_d   = a_i;
          bOp_d   = b_i;
          dbz_d   = 1'b0;
          ovf_d   = 1'b0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        magB_d  = W1'(applySign(bOp_q[N-1], MaxW'({bOp_q[N-1], bOp_q})));
        quo_d   = N'(applySign(aOp_q[N-1], MaxW'({aOp_q[N-1], aOp_q})));
        p_d     = '0;
        sq_d    = aOp_q[N-1] ^ bOp_q[N-1];
        sr_d    = aOp_q[N-1];
        isDbz_d = (bOp_q == '0);
        isOvf_d = (aOp_q == MinNeg) && (bOp_q == '1);
        cnt_d   = CW'(N - 1);
        state_d = CALC;
      end
      CALC: begin
        p_d   = addSum;
        quo_d = {quo_q[N-2:0], ~addSum[PW-1]};
        if (cnt_q == '0) begin
          state_d = FIX;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      FIX: begin
        q_d     = qFix;
        r_d     = rFix;
        dbz_d   = isDbz_q;
        ovf_d   = isOvf_q;
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      aOp_q   <= '0;
      bOp_q   <= '0;
      magB_q  <= '0;
      p_q     <= '0;
      quo_q   <= '0;
      sq_q    <= 1'b0;
      sr_q    <= 1'b0;
      isDbz_q <= 1'b0;
      isOvf_q <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      aOp_q   <= aOp_d;
      bOp_q   <= bOp_d;
      magB_q  <= magB_d;
      p_q     <= p_d;
      quo_q   <= quo_d;
      sq_q    <= sq_d;
      sr_q    <= sr_d;
      isDbz_q <= isDbz_d;
      isOvf_q <= isOvf_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
    end
  end

  // Results appear during the FIX cycle and are held in registers afterwards.
  always_comb begin
    done_o = (state_q == FIX);
    busy_o = (state_q != IDLE);
    q_o    = done_o ? qFix : q_q;
    r_o    = done_o ? rFix : r_q;
    dbz_o  = done_o ? isDbz_q : dbz_q;
    ovf_o  = done_o ? isOvf_q : ovf_q;
  end

endmodule

// File: tb/tb_sdiv_seq.sv
// Directed and exhaustive checks for the 4-bit sequential signed divider.
module tb_sdiv_seq;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic [3:0] q;
  logic [3:0] r;
  logic       busy;
  logic       done;
  logic       dbz;
  logic       ovf;

  int testsRun;
  int testsFailed;

  sdiv_seq #(.N(4)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .start_i(start),
    .a_i    (a),
    .b_i    (b),
    .q_o    (q),
    .r_o    (r),
    .busy_o (busy),
    .done_o (done),
    .dbz_o  (dbz),
    .ovf_o  (ovf)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Start one division from idle and wait (bounded) for done; lat is the cycle index of done.
  task automatic applyStimulus(input logic [3:0] aVal, input logic [3:0] bVal, output int lat);
    @(posedge clk); #1;
    a = aVal;
    b = bVal;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    testsRun++; if (q !== 4'd0)    begin testsFailed++; $display("[TB] FAIL reset q: got %0h, expected 0", q); end
    testsRun++; if (r !== 4'd0)    begin testsFailed++; $display("[TB] FAIL reset r: got %0h, expected 0", r); end
    testsRun++; if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset busy: got %b, expected 0", busy); end
    testsRun++; if (done !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset done: got %b, expected 0", done); end
    testsRun++; if (dbz !== 1'b0)  begin testsFailed++; $display("[TB] FAIL reset dbz: got %b, expected 0", dbz); end
    testsRun++; if (ovf !== 1'b0)  begin testsFailed++; $display("[TB] FAIL reset ovf: got %b, expected 0", ovf); end
    rst = 1'b0;
  endtask

  task automatic test_basic;
    int lat;
    applyStimulus(4'd7, 4'd2, lat);
    testsRun++; if (lat !== 6)    begin testsFailed++; $display("[TB] FAIL 7/2 latency: got %0d, expected 6", lat); end
    testsRun++; if (q !== 4'd3)   begin testsFailed++; $display("[TB] FAIL 7/2 q: got %0h, expected 3", q); end
    testsRun++; if (r !== 4'd1)   begin testsFailed++; $display("[TB] FAIL 7/2 r: got %0h, expected 1", r); end
    testsRun++; if (dbz !== 1'b0) begin testsFailed++; $display("[TB] FAIL 7/2 dbz: got %b, expected 0", dbz); end
    testsRun++; if (ovf !== 1'b0) begin testsFailed++; $display("[TB] FAIL 7/2 ovf: got %b, expected 0", ovf); end
    testsRun++; if (busy !== 1'b1) begin testsFailed++; $display("[TB] FAIL 7/2 busy in done cycle: got %b, expected 1", busy); end
    @(posedge clk); #1;
    testsRun++; if (done !== 1'b0) begin testsFailed++; $display("[TB] FAIL 7/2 done pulse width: got %b, expected 0", done); end
    testsRun++; if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL 7/2 busy after done: got %b, expected 0", busy); end
    testsRun++; if (q !== 4'd3)    begin testsFailed++; $display("[TB] FAIL 7/2 q held: got %0h, expected 3", q); end
    testsRun++; if (r !== 4'd1)    begin testsFailed++; $display("[TB] FAIL 7/2 r held: got %0h, expected 1", r); end
  endtask

  task automatic test_signs;
    logic [3:0] va [3];
    logic [3:0] vb [3];
    logic [3:0] eq [3];
    logic [3:0] er [3];
    int lat;
    // -7/2 -> -3 rem -1 ; 7/-2 -> -3 rem 1 ; -7/-2 -> 3 rem -1
    va = '{4'h9, 4'h7, 4'h9};
    vb = '{4'h2, 4'hE, 4'hE};
    eq = '{4'hD, 4'hD, 4'h3};
    er = '{4'hF, 4'h1, 4'hF};
    for (int i = 0; i < 3; i++) begin
      applyStimulus(va[i], vb[i], lat);
      testsRun++; if (q !== eq[i]) begin testsFailed++; $display("[TB] FAIL signs %0h/%0h q: got %0h, expected %0h", va[i], vb[i], q, eq[i]); end
      testsRun++; if (r !== er[i]) begin testsFailed++; $display("[TB] FAIL signs %0h/%0h r: got %0h, expected %0h", va[i], vb[i], r, er[i]); end
      testsRun++; if ({dbz, ovf} !== 2'b00) begin testsFailed++; $display("[TB] FAIL signs %0h/%0h flags: got %b, expected 00", va[i], vb[i], {dbz, ovf}); end
    end
  endtask

  task automatic test_overflow;
    int lat;
    applyStimulus(4'h8, 4'hF, lat);
    testsRun++; if (q !== 4'h8)   begin testsFailed++; $display("[TB] FAIL -8/-1 q: got %0h, expected 8", q); end
    testsRun++; if (r !== 4'h0)   begin testsFailed++; $display("[TB] FAIL -8/-1 r: got %0h, expected 0", r); end
    testsRun++; if (ovf !== 1'b1) begin testsFailed++; $display("[TB] FAIL -8/-1 ovf: got %b, expected 1", ovf); end
    testsRun++; if (dbz !== 1'b0) begin testsFailed++; $display("[TB] FAIL -8/-1 dbz: got %b, expected 0", dbz); end
    testsRun++; if (lat !== 6)    begin testsFailed++; $display("[TB] FAIL -8/-1 latency: got %0d, expected 6", lat); end
    applyStimulus(4'h8, 4'h1, lat);
    testsRun++; if (q !== 4'h8)   begin testsFailed++; $display("[TB] FAIL -8/1 q: got %0h, expected 8", q); end
    testsRun++; if (r !== 4'h0)   begin testsFailed++; $display("[TB] FAIL -8/1 r: got %0h, expected 0", r); end
    testsRun++; if (ovf !== 1'b0) begin testsFailed++; $display("[TB] FAIL -8/1 ovf: got %b, expected 0", ovf); end
  endtask

  task automatic test_div_by_zero;
    int lat;
    applyStimulus(4'd5, 4'd0, lat);
    testsRun++; if (lat !== 6)    begin testsFailed++; $display("[TB] FAIL 5/0 latency: got %0d, expected 6", lat); end
    testsRun++; if (q !== 4'hF)   begin testsFailed++; $display("[TB] FAIL 5/0 q: got %0h, expected f", q); end
    testsRun++; if (r !== 4'h5)   begin testsFailed++; $display("[TB] FAIL 5/0 r: got %0h, expected 5", r); end
    testsRun++; if (dbz !== 1'b1) begin testsFailed++; $display("[TB] FAIL 5/0 dbz: got %b, expected 1", dbz); end
    testsRun++; if (ovf !== 1'b0) begin testsFailed++; $display("[TB] FAIL 5/0 ovf: got %b, expected 0", ovf); end
  endtask

  task automatic test_back_to_back;
    int lat;
    @(posedge clk); #1;
    a = 4'd3; b = 4'd3; start = 1'b1;
    @(posedge clk); #1;                 // accepting edge k passed, now cycle k+1
    start = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    a = 4'd6; b = 4'd2; start = 1'b1;   // cycle k+3, must be ignored
    @(posedge clk); #1;
    start = 1'b0;
    testsRun++; if (busy !== 1'b1) begin testsFailed++; $display("[TB] FAIL b2b busy k+4: got %b, expected 1", busy); end
    repeat (2) begin @(posedge clk); #1; end
    testsRun++; if (done !== 1'b1) begin testsFailed++; $display("[TB] FAIL b2b first done k+6: got %b, expected 1", done); end
    testsRun++; if (q !== 4'd1)    begin testsFailed++; $display("[TB] FAIL b2b first q: got %0h, expected 1", q); end
    testsRun++; if (r !== 4'd0)    begin testsFailed++; $display("[TB] FAIL b2b first r: got %0h, expected 0", r); end
    @(posedge clk); #1;
    testsRun++; if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL b2b busy k+7: got %b, expected 0", busy); end
    a = 4'd6; b = 4'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 40) begin @(posedge clk); #1; lat++; end
    testsRun++; if (lat !== 6)  begin testsFailed++; $display("[TB] FAIL b2b second latency: got %0d, expected 6", lat); end
    testsRun++; if (q !== 4'd3) begin testsFailed++; $display("[TB] FAIL b2b second q: got %0h, expected 3", q); end
    testsRun++; if (r !== 4'd0) begin testsFailed++; $display("[TB] FAIL b2b second r: got %0h, expected 0", r); end
  endtask

  task automatic test_start_during_done;
    int lat;
    int seen;
    applyStimulus(4'd7, 4'd2, lat);
    a = 4'd1; b = 4'd1; start = 1'b1;   // same cycle as done
    @(posedge clk); #1;
    start = 1'b0;
    testsRun++; if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL start in done cycle busy: got %b, expected 0", busy); end
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (done === 1'b1) seen++;
      @(posedge clk); #1;
    end
    testsRun++; if (seen !== 0) begin testsFailed++; $display("[TB] FAIL start in done cycle spurious done: got %0d, expected 0", seen); end
  endtask

  task automatic test_reset_abort;
    int seen;
    @(posedge clk); #1;
    a = 4'h9; b = 4'd3; start = 1'b1;   // -7 / 3
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    testsRun++; if (q !== 4'd3) begin testsFailed++; $display("[TB] FAIL abort q held before reset: got %0h, expected 3", q); end
    rst = 1'b1;                         // cycle k+3
    @(posedge clk); #1;
    rst = 1'b0;
    testsRun++; if ({q, r} !== 8'h00)          begin testsFailed++; $display("[TB] FAIL abort q/r: got %0h, expected 0", {q, r}); end
    testsRun++; if ({busy, done} !== 2'b00)    begin testsFailed++; $display("[TB] FAIL abort busy/done: got %b, expected 00", {busy, done}); end
    testsRun++; if ({dbz, ovf} !== 2'b00)      begin testsFailed++; $display("[TB] FAIL abort flags: got %b, expected 00", {dbz, ovf}); end
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (done === 1'b1) seen++;
      @(posedge clk); #1;
    end
    testsRun++; if (seen !== 0) begin testsFailed++; $display("[TB] FAIL abort done seen: got %0d, expected 0", seen); end
  endtask

  task automatic test_exhaustive;
    for (int ia = -8; ia < 8; ia++) begin
      for (int ib = -8; ib < 8; ib++) begin
        int eq;
        int er;
        int lat;
        int chk;
        logic eDbz;
        logic eOvf;
        eDbz = 1'b0;
        eOvf = 1'b0;
        if (ib == 0) begin
          eq = -1; er = ia; eDbz = 1'b1;
        end else if (ia == -8 && ib == -1) begin
          eq = -8; er = 0; eOvf = 1'b1;
        end else begin
          eq = ia / ib; er = ia % ib;
        end
        applyStimulus(4'(ia), 4'(ib), lat);
        testsRun++; if (lat !== 6)  begin testsFailed++; $display("[TB] FAIL exh %0d/%0d latency: got %0d, expected 6", ia, ib, lat); end
        testsRun++; if (q !== 4'(eq)) begin testsFailed++; $display("[TB] FAIL exh %0d/%0d q: got %0h, expected %0h", ia, ib, q, 4'(eq)); end
        testsRun++; if (r !== 4'(er)) begin testsFailed++; $display("[TB] FAIL exh %0d/%0d r: got %0h, expected %0h", ia, ib, r, 4'(er)); end
        testsRun++; if ({dbz, ovf} !== {eDbz, eOvf}) begin testsFailed++; $display("[TB] FAIL exh %0d/%0d flags: got %b, expected %b", ia, ib, {dbz, ovf}, {eDbz, eOvf}); end
        if (ib != 0) begin
          chk = $signed(q) * ib + $signed(r);
          testsRun++; if (4'(chk) !== 4'(ia)) begin testsFailed++; $display("[TB] FAIL exh %0d/%0d q*b+r: got %0h, expected %0h", ia, ib, 4'(chk), 4'(ia)); end
        end
      end
    end
  endtask

  // Test sequence.
  initial begin
    clk = 1'b0;
    rst = 1'b1;
    start = 1'b0;
    a = 4'd0;
    b = 4'd0;
    testsRun = 0;
    testsFailed = 0;
    test_reset();
    test_basic();
    test_signs();
    test_overflow();
    test_div_by_zero();
    test_back_to_back();
    test_start_during_done();
    test_reset_abort();
    test_exhaustive();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
